// File: rtl/bist_sequencer.sv
// bist_sequencer: start-triggered, abortable BIST session controller.
// Seeds the LFSR/MISR, steps them for PATTERNS cycles and then compares the
// final MISR signature against GOLDEN. It reports the result on done/pass.
//
// Control handshake: start_i and abort_i are level-sampled on each rising
// edge with no valid/ready pairing. start_i is honoured only in IDLE or DONE
// and is never queued. abort_i is honoured in every non-IDLE state and wins
// over start_i. There is no back-pressure path.
module bist_sequencer #(
  parameter int unsigned      PATTERNS = 63,
  parameter int unsigned      CNT_W    = 6,
  parameter int unsigned      SIG_W    = 3,
  parameter logic [SIG_W-1:0] GOLDEN   = 3'b101
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [SIG_W-1:0] sig_i,
  output logic             tm_o,
  output logic             gen_clr_o,
  output logic             gen_en_o,
  output logic             misr_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] pat_cnt_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Count value seen on the last RUN edge. With PATTERNS = 2^CNT_W the
  // counter then naturally wraps to 0 when it moves into CHECK.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] pat_cnt_q;
  logic [CNT_W-1:0] pat_cnt_d;
  logic             done_q;
  logic             pass_q;

  assign pat_cnt_d = pat_cnt_q + CNT_W'(1);

  // Session FSM: state, pattern counter and the sticky done/pass flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pat_cnt_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_q   <= S_INIT;
            pat_cnt_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        S_INIT: begin
          pat_cnt_q <= '0;
          done_q    <= 1'b0;
          pass_q    <= 1'b0;
          state_q   <= abort_i ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          // The pattern of this cycle has been applied even if we abort,
          // so the count always advances; an abort then freezes it.
          pat_cnt_q <= pat_cnt_d;
          if (abort_i) begin
            state_q <= S_IDLE;
          end else if (pat_cnt_q == LAST_CNT) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else begin
            pass_q  <= (sig_i == GOLDEN);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (start_i) begin
            state_q   <= S_INIT;
            pat_cnt_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  // Moore decode of the control strobes from the state register alone.
  always_comb begin
    tm_o      = 1'b0;
    gen_clr_o = 1'b0;
    gen_en_o  = 1'b0;
    misr_en_o = 1'b0;
    busy_o    = 1'b0;
    case (state_q)
      S_INIT: begin
        tm_o      = 1'b1;
        gen_clr_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_RUN: begin
        tm_o      = 1'b1;
        gen_en_o  = 1'b1;
        misr_en_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_CHECK: begin
        tm_o   = 1'b1;
        busy_o = 1'b1;
      end
      default: begin
        tm_o = 1'b0;
      end
    endcase
  end

  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign pat_cnt_o = pat_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: a default 63-pattern instance driven by
// a small LFSR / 6:3-counter / MISR model, plus a PATTERNS=1 instance.
module tb_bist_sequencer;

  localparam int W = 7;  // {pass, pat_cnt}
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic       start = 1'b0, abort = 1'b0;
  logic [2:0] sig;
  logic       tm, gen_clr, gen_en, misr_en, busy, done, pass;
  logic [5:0] pat_cnt;
  logic [2:0] state;

  bist_sequencer u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .sig_i(sig),
    .tm_o(tm), .gen_clr_o(gen_clr), .gen_en_o(gen_en), .misr_en_o(misr_en),
    .busy_o(busy), .done_o(done), .pass_o(pass), .pat_cnt_o(pat_cnt), .state_o(state)
  );

  // ---------------- PATTERNS=1 instance ----------------
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [2:0] sig1 = 3'b101;
  logic       tm1, gen_clr1, gen_en1, misr_en1, busy1, done1, pass1;
  logic [5:0] pat_cnt1;
  logic [2:0] state1;

  bist_sequencer #(.PATTERNS(1)) u_one (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(abort1), .sig_i(sig1),
    .tm_o(tm1), .gen_clr_o(gen_clr1), .gen_en_o(gen_en1), .misr_en_o(misr_en1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .pat_cnt_o(pat_cnt1), .state_o(state1)
  );

  // ---------------- LFSR -> 6:3 counter -> MISR model ----------------
  logic [5:0] lfsr_q = 6'd1;
  logic [2:0] misr_q = 3'd0;
  logic       frc_en = 1'b0;
  logic [2:0] frc_val = 3'd0;

  assign sig = frc_en ? frc_val : misr_q;

  always @(posedge clk) begin
    if (gen_clr) begin
      lfsr_q <= 6'd1;
      misr_q <= 3'd0;
    end else begin
      if (gen_en)  lfsr_q <= {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
      if (misr_en) misr_q <= {misr_q[1:0], misr_q[2] ^ misr_q[1]} ^ 3'($countones(lfsr_q));
    end
  end

  function automatic logic [2:0] model_sig(input int n);
    logic [5:0] l;
    logic [2:0] m;
    l = 6'd1;
    m = 3'd0;
    for (int i = 0; i < n; i++) begin
      m = {m[1:0], m[2] ^ m[1]} ^ 3'($countones(l));
      l = {l[4:0], l[5] ^ l[4]};
    end
    return m;
  endfunction

  // ---------------- strobe counters (cycles the strobe was high) ----------------
  int gen_en_cnt = 0, misr_en_cnt = 0, gen_clr_cnt = 0;
  int gen_en1_cnt = 0, gen_clr1_cnt = 0;
  always @(posedge clk) begin
    if (gen_en)   gen_en_cnt++;
    if (misr_en)  misr_en_cnt++;
    if (gen_clr)  gen_clr_cnt++;
    if (gen_en1)  gen_en1_cnt++;
    if (gen_clr1) gen_clr1_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tm"},      32'(tm), 0);
    check({tag, "_gen_en"},  32'(gen_en), 0);
    check({tag, "_misr_en"}, 32'(misr_en), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_done"},    32'(done), 0);
    check({tag, "_pass"},    32'(pass), 0);
    check({tag, "_state"},   32'(state), 32'(ST_IDLE));
  endtask

  // One session on the default instance. Called at a negedge.
  // restart_at >= 0 pulses start at that count; abort_at >= 0 aborts there.
  task automatic run_session(input bit frc, input logic [2:0] fv,
                             input int restart_at, input int abort_at);
    int           cyc;
    logic [W-1:0] exp;
    logic         exp_pass;
    frc_en      = frc;
    frc_val     = fv;
    gen_en_cnt  = 0;
    misr_en_cnt = 0;
    gen_clr_cnt = 0;
    exp_pass = frc ? (fv == 3'b101) : (model_sig(63) == 3'b101);
    exp_q.push_back({exp_pass, 6'd63});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("init_gen_clr", 32'(gen_clr), 1);
    check("init_tm",      32'(tm), 1);
    check("init_busy",    32'(busy), 1);
    check("init_done",    32'(done), 0);
    check("init_pat_cnt", 32'(pat_cnt), 0);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (abort_at >= 0 && state == ST_RUN && int'(pat_cnt) == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(exp_q.pop_back());
        check_idle_outputs("abort");
        check("abort_pat_cnt", 32'(pat_cnt), 32'(abort_at + 1));
        check("abort_gen_en_cycles", 32'(gen_en_cnt), 32'(abort_at + 1));
        return;
      end
      start = (restart_at >= 0 && int'(pat_cnt) == restart_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 65);
    exp = exp_q.pop_front();
    check("result_pass_cnt", 32'({pass, pat_cnt}), 32'(exp));
    check("gen_en_cycles",  32'(gen_en_cnt), 63);
    check("misr_en_cycles", 32'(misr_en_cnt), 63);
    check("gen_clr_cycles", 32'(gen_clr_cnt), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int           cyc;
    logic [W-1:0] exp;

    // Reset state.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_pat_cnt", 32'(pat_cnt), 0);
    check("reset_one_done", 32'(done1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full session with the LFSR/MISR model feeding sig.
    run_session(1'b0, 3'd0, -1, -1);

    // Results are sticky in DONE with test mode released.
    repeat (3) @(negedge clk);
    check("sticky_done", 32'(done), 1);
    check("done_tm",     32'(tm), 0);
    check("done_busy",   32'(busy), 0);
    check("done_gen_en", 32'(gen_en), 0);
    check("done_pat_cnt", 32'(pat_cnt), 63);

    // Restart from DONE, golden signature, extra start at pat_cnt=20 ignored.
    run_session(1'b1, 3'b101, 20, -1);

    // Wrong signature -> pass=0.
    run_session(1'b1, 3'b010, -1, -1);

    // Abort mid-RUN at pat_cnt=10.
    run_session(1'b0, 3'd0, -1, 10);
    repeat (2) @(negedge clk);
    check("abort_stays_idle", 32'(state), 32'(ST_IDLE));

    // Asynchronous reset between edges mid-RUN.
    frc_en = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (int'(pat_cnt) != 30 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_cnt30", 32'(pat_cnt), 30);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_pat_cnt", 32'(pat_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_session(1'b0, 3'd0, -1, -1);

    // PATTERNS=1 instance, two back-to-back sessions.
    for (int s = 0; s < 2; s++) begin
      gen_en1_cnt  = 0;
      gen_clr1_cnt = 0;
      exp_q.push_back({1'b1, 6'd1});
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("one_init_done",    32'(done1), 0);
      check("one_init_gen_clr", 32'(gen_clr1), 1);
      cyc = 0;
      while (!done1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("one_latency", 32'(cyc), 3);
      exp = exp_q.pop_front();
      check("one_result", 32'({pass1, pat_cnt1}), 32'(exp));
      check("one_gen_en_cycles",  32'(gen_en1_cnt), 1);
      check("one_gen_clr_cycles", 32'(gen_clr1_cnt), 1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
